// File: rtl/cdc_pkg.sv
// cdc_pkg: shared definitions for the clock-domain-crossing blocks.
//   hs_state_t - states of the four-phase handshake source FSM.
//   cnt_width  - counter width able to hold 0..timeout (never below 1 bit).
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } hs_state_t;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: NUM_OF_STAGE-deep flop chain bringing an asynchronous
// level into the clk domain. Flops clear asynchronously to 0.
//   clk      - destination clock
//   reset_n  - active-low asynchronous reset
//   data_in  - asynchronous input level(s)
//   data_out - synchronized output, last stage of the chain
module bit_synchronizer #(
  parameter int WIDTH        = 1,
  parameter int NUM_OF_STAGE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [NUM_OF_STAGE-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[NUM_OF_STAGE-2:0], data_in};
    end
  end

  assign data_out = stage[NUM_OF_STAGE-1];

endmodule

// File: rtl/sync_handshake_tx.sv
// sync_handshake_tx: transmit half of a four-phase req/ack CDC path.
// Accepts a word from a valid/ready producer, holds it on data_out and
// raises req_out, then walks the handshake against a synchronized ack.
// A watchdog flags a phase that lasts TIMEOUT cycles; it never aborts.
//   clk, reset   - clock and synchronous active-high reset
//   src_valid    - producer has a word
//   src_data     - producer's word
//   src_ready    - block can accept a word this cycle
//   ack_async    - acknowledge from the destination domain
//   req_out      - registered request to the destination
//   data_out     - captured word, stable while busy
//   busy         - handshake in progress (REQ or DROP)
//   xfer_done    - one-cycle pulse when the destination acknowledges
//   timeout_err  - sticky watchdog flag
//   err_clr      - clears timeout_err (a simultaneous set wins)
module sync_handshake_tx
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  input  logic             ack_async,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             xfer_done,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int unsigned          CNT_W     = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]     TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam bit                   WD_EN     = (TIMEOUT != 0);

  hs_state_t        state, state_nx;
  logic             ack_s;
  logic             accept;
  logic             to_drop;
  logic             wd_fire;
  logic [CNT_W-1:0] wd_cnt;

  bit_synchronizer #(
    .WIDTH        (1),
    .NUM_OF_STAGE (SYNC_STAGES)
  ) u_ack_sync (
    .clk      (clk),
    .reset_n  (~reset),
    .data_in  (ack_async),
    .data_out (ack_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A new word is only taken once the previous ack has been seen low, so
  // a stale ack (e.g. after reset mid-transfer) cannot complete it.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    to_drop   = 1'b0;
    src_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        src_ready = ~ack_s;
        if (src_valid && !ack_s) begin
          accept   = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          to_drop  = 1'b1;
          state_nx = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!ack_s) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_out   <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      busy      <= (state_nx != ST_IDLE);
      xfer_done <= to_drop;
      if (accept) begin
        data_out <= src_data;
        req_out  <= 1'b1;
      end else if (to_drop) begin
        req_out <= 1'b0;
      end
    end
  end

  // Counter is held at zero in IDLE so a saturated value cannot keep
  // re-setting the flag once the handshake has finished.
  assign wd_fire = WD_EN && (state != ST_IDLE) && (wd_cnt == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept || to_drop || state == ST_IDLE) begin
        wd_cnt <= '0;
      end else if (wd_cnt != TIMEOUT_C) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (wd_fire) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
